// File: rtl/router_fsm_if.sv
// Source-side packet handshake of the 1x3 router: valid + header address in, busy back out.
interface router_fsm_if;
  logic       packet_valid;
  logic [1:0] datain;
  logic       busy;

  modport master (output packet_valid, output datain, input busy);
  modport slave  (input packet_valid, input datain, output busy);
endinterface

// File: rtl/router_fsm.sv
// Control FSM for the 1x3 router: decodes the header, waits for an empty target FIFO, then
// sequences header/payload/full-stall/parity loads. Outputs are registered Moore decodes of the next state.
module router_fsm #(
  parameter int WAIT_TIMEOUT = 1024,
  parameter int CNT_W        = 11
) (
  input  logic            clk,
  input  logic            reset,
  router_fsm_if.slave     src,
  input  logic            fifo_full,
  input  logic            fifo_empty_0,
  input  logic            fifo_empty_1,
  input  logic            fifo_empty_2,
  input  logic            soft_reset_0,
  input  logic            soft_reset_1,
  input  logic            soft_reset_2,
  input  logic            parity_done,
  input  logic            low_packet_valid,
  output logic            detect_add,
  output logic            lfd_state,
  output logic            ld_state,
  output logic            laf_state,
  output logic            full_state,
  output logic            rst_int_reg,
  output logic            write_enb_reg,
  output logic [1:0]      addr,
  output logic            wait_timeout
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    WAIT_TILL_EMPTY    = 3'd1,
    LOAD_FIRST_DATA    = 3'd2,
    LOAD_DATA          = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    LOAD_PARITY        = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

  localparam bit             TIMEOUT_EN   = (WAIT_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'((WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0);

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_fire;
  logic [2:0]       empty_vec;
  logic [2:0]       soft_vec;
  logic             addr_ok;

  assign empty_vec = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign soft_vec  = {soft_reset_2, soft_reset_1, soft_reset_0};
  assign addr_ok   = src.packet_valid && (src.datain != 2'd3);

  always_comb begin
    nxt          = state;
    timeout_fire = 1'b0;
    // Only the soft reset of the port currently being written can abort a packet.
    if (state != DECODE_ADDRESS && soft_vec[addr]) begin
      nxt = DECODE_ADDRESS;
    end else begin
      case (state)
        DECODE_ADDRESS:
          if (addr_ok) nxt = empty_vec[src.datain] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        WAIT_TILL_EMPTY:
          if (empty_vec[addr]) begin
            nxt = LOAD_FIRST_DATA;
          end else if (TIMEOUT_EN && wait_cnt == TIMEOUT_LAST) begin
            nxt          = DECODE_ADDRESS;
            timeout_fire = 1'b1;
          end
        LOAD_FIRST_DATA:
          nxt = LOAD_DATA;
        LOAD_DATA:
          if (fifo_full)              nxt = FIFO_FULL_STATE;
          else if (!src.packet_valid) nxt = LOAD_PARITY;
        FIFO_FULL_STATE:
          if (!fifo_full) nxt = LOAD_AFTER_FULL;
        LOAD_AFTER_FULL:
          if (parity_done)           nxt = DECODE_ADDRESS;
          else if (low_packet_valid) nxt = LOAD_PARITY;
          else                       nxt = LOAD_DATA;
        LOAD_PARITY:
          nxt = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR:
          nxt = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        default:
          nxt = DECODE_ADDRESS;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= DECODE_ADDRESS;
      addr          <= 2'd0;
      wait_cnt      <= '0;
      wait_timeout  <= 1'b0;
      detect_add    <= 1'b1;
      lfd_state     <= 1'b0;
      ld_state      <= 1'b0;
      laf_state     <= 1'b0;
      full_state    <= 1'b0;
      rst_int_reg   <= 1'b0;
      write_enb_reg <= 1'b0;
      src.busy      <= 1'b0;
    end else begin
      state        <= nxt;
      wait_timeout <= timeout_fire;
      if (state == DECODE_ADDRESS && addr_ok) addr <= src.datain;
      wait_cnt <= (state == WAIT_TILL_EMPTY && nxt == WAIT_TILL_EMPTY) ? wait_cnt + 1'b1 : '0;
      // Outputs follow the next state so they line up with the registered state.
      detect_add    <= (nxt == DECODE_ADDRESS);
      lfd_state     <= (nxt == LOAD_FIRST_DATA);
      ld_state      <= (nxt == LOAD_DATA);
      laf_state     <= (nxt == LOAD_AFTER_FULL);
      full_state    <= (nxt == FIFO_FULL_STATE);
      rst_int_reg   <= (nxt == CHECK_PARITY_ERROR);
      write_enb_reg <= (nxt == LOAD_FIRST_DATA) || (nxt == LOAD_DATA) ||
                       (nxt == LOAD_AFTER_FULL) || (nxt == LOAD_PARITY);
      src.busy      <= !((nxt == DECODE_ADDRESS) || (nxt == LOAD_DATA));
    end
  end

endmodule

// File: tb/tb_router_fsm.sv
// Randomized and directed bench for router_fsm against a packet-level reference model.
module tb_router_fsm;

  localparam int TMO = 8;
  localparam logic [10:0] RESET_OUT = 11'b10000000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       packet_valid;
  logic [1:0] datain;
  logic       fifo_full;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       parity_done, low_packet_valid;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       rst_int_reg, write_enb_reg, wait_timeout;
  logic [1:0] addr;

  router_fsm_if bus();
  assign bus.packet_valid = packet_valid;
  assign bus.datain       = datain;

  router_fsm #(.WAIT_TIMEOUT(TMO), .CNT_W(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .src              (bus),
    .fifo_full        (fifo_full),
    .fifo_empty_0     (fifo_empty_0),
    .fifo_empty_1     (fifo_empty_1),
    .fifo_empty_2     (fifo_empty_2),
    .soft_reset_0     (soft_reset_0),
    .soft_reset_1     (soft_reset_1),
    .soft_reset_2     (soft_reset_2),
    .parity_done      (parity_done),
    .low_packet_valid (low_packet_valid),
    .detect_add       (detect_add),
    .lfd_state        (lfd_state),
    .ld_state         (ld_state),
    .laf_state        (laf_state),
    .full_state       (full_state),
    .rst_int_reg      (rst_int_reg),
    .write_enb_reg    (write_enb_reg),
    .addr             (addr),
    .wait_timeout     (wait_timeout)
  );

  // Bit order: detect_add, lfd, ld, laf, full, rst_int, write_enb, busy, addr[1:0], wait_timeout
  wire [10:0] obs = {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
                     write_enb_reg, bus.busy, addr, wait_timeout};

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef enum {M_DA, M_WAIT, M_LFD, M_LD, M_FULL, M_LAF, M_LP, M_CPE} mstate_e;
  mstate_e    m_st     = M_DA;
  logic [1:0] m_addr   = 2'd0;
  int         m_waited = 0;
  logic       m_to     = 1'b0;

  function automatic logic [10:0] exp_out();
    logic we, bsy;
    we  = (m_st == M_LFD) || (m_st == M_LD) || (m_st == M_LAF) || (m_st == M_LP);
    bsy = !((m_st == M_DA) || (m_st == M_LD));
    return {m_st == M_DA, m_st == M_LFD, m_st == M_LD, m_st == M_LAF, m_st == M_FULL,
            m_st == M_CPE, we, bsy, m_addr, m_to};
  endfunction

  function automatic void model_update();
    logic [2:0] emp, srv;
    emp  = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    srv  = {soft_reset_2, soft_reset_1, soft_reset_0};
    m_to = 1'b0;
    if (reset) begin
      m_st = M_DA; m_addr = 2'd0; m_waited = 0;
    end else if (m_st != M_DA && srv[m_addr]) begin
      m_st = M_DA; m_waited = 0;
    end else begin
      case (m_st)
        M_DA: if (packet_valid && datain != 2'd3) begin
          m_addr = datain;
          m_st   = emp[datain] ? M_LFD : M_WAIT;
          m_waited = 0;
        end
        M_WAIT: begin
          m_waited++;
          if (emp[m_addr]) begin
            m_st = M_LFD; m_waited = 0;
          end else if (TMO != 0 && m_waited == TMO) begin
            m_st = M_DA; m_to = 1'b1; m_waited = 0;
          end
        end
        M_LFD:  m_st = M_LD;
        M_LD:   if (fifo_full) m_st = M_FULL; else if (!packet_valid) m_st = M_LP;
        M_FULL: if (!fifo_full) m_st = M_LAF;
        M_LAF:  m_st = parity_done ? M_DA : (low_packet_valid ? M_LP : M_LD);
        M_LP:   m_st = M_CPE;
        M_CPE:  m_st = fifo_full ? M_FULL : M_DA;
        default: m_st = M_DA;
      endcase
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; packet_valid = 1'b0; datain = 2'd0; fifo_full = 1'b0;
    fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
    soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
    parity_done = 1'b0; low_packet_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1; packet_valid = 1'b1; datain = 2'd2; fifo_full = 1'b1;
    step();
    total++;
    if (obs !== RESET_OUT) begin
      bad++; $display("FAIL reset_const got=%b want=%b", obs, RESET_OUT);
    end
    total++;
    if (obs !== exp_out()) begin
      bad++; $display("FAIL reset_model got=%b want=%b", obs, exp_out());
    end
    reset = 1'b0;
  endtask

  task automatic test_direct();
    do_reset();
    packet_valid = 1'b1; datain = 2'd1;
    for (int i = 0; i < 8; i++) begin
      if (i == 5) packet_valid = 1'b0;
      step();
      total++;
      if (obs !== exp_out()) begin
        bad++; $display("FAIL direct cyc=%0d got=%b want=%b", i, obs, exp_out());
      end
      if (i == 0) begin
        total++;
        if ({lfd_state, addr, bus.busy} !== 4'b1011) begin
          bad++; $display("FAIL direct_lfd got=%b want=1011", {lfd_state, addr, bus.busy});
        end
      end
      if (i == 6) begin
        total++;
        if (rst_int_reg !== 1'b1) begin
          bad++; $display("FAIL direct_cpe got=%b want=1", rst_int_reg);
        end
      end
    end
  endtask

  task automatic test_busy_dest();
    do_reset();
    packet_valid = 1'b1; datain = 2'd2; fifo_empty_2 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) fifo_empty_2 = 1'b1;
      if (i == 7) packet_valid = 1'b0;
      step();
      total++;
      if (obs !== exp_out()) begin
        bad++; $display("FAIL busy_dest cyc=%0d got=%b want=%b", i, obs, exp_out());
      end
      if (i < 5) begin
        total++;
        if ({bus.busy, write_enb_reg} !== 2'b10) begin
          bad++; $display("FAIL busy_wait cyc=%0d got=%b want=10", i, {bus.busy, write_enb_reg});
        end
      end
      if (i == 5) begin
        total++;
        if ({lfd_state, addr} !== 3'b110) begin
          bad++; $display("FAIL busy_lfd got=%b want=110", {lfd_state, addr});
        end
      end
    end
  endtask

  task automatic test_invalid_addr();
    logic [1:0] held;
    held = addr;
    idle();
    packet_valid = 1'b1; datain = 2'd3;
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if ({detect_add, bus.busy, addr} !== {2'b10, held}) begin
        bad++; $display("FAIL invalid cyc=%0d got=%b want=%b", i, {detect_add, bus.busy, addr}, {2'b10, held});
      end
    end
  endtask

  task automatic test_fifo_full();
    do_reset();
    packet_valid = 1'b1; datain = 2'd0;
    for (int i = 0; i < 12; i++) begin
      fifo_full   = (i >= 2 && i <= 4) || (i == 7);
      parity_done = (i == 9);
      step();
      total++;
      if (obs !== exp_out()) begin
        bad++; $display("FAIL full cyc=%0d got=%b want=%b", i, obs, exp_out());
      end
      if (i >= 2 && i <= 4) begin
        total++;
        if ({full_state, bus.busy, write_enb_reg} !== 3'b110) begin
          bad++; $display("FAIL full_stall cyc=%0d got=%b want=110", i, {full_state, bus.busy, write_enb_reg});
        end
      end
      if (i == 9) begin
        total++;
        if (detect_add !== 1'b1) begin
          bad++; $display("FAIL full_parity_done got=%b want=1", detect_add);
        end
      end
    end
  endtask

  task automatic test_soft_reset();
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      packet_valid = 1'b1; datain = 2'd0;
      step(); step();
      if (pass == 0) soft_reset_0 = 1'b1; else soft_reset_1 = 1'b1;
      step();
      soft_reset_0 = 1'b0; soft_reset_1 = 1'b0;
      total++;
      if ({detect_add, ld_state} !== ((pass == 0) ? 2'b10 : 2'b01)) begin
        bad++; $display("FAIL soft_reset pass=%0d got=%b", pass, {detect_add, ld_state});
      end
      total++;
      if (obs !== exp_out()) begin
        bad++; $display("FAIL soft_model pass=%0d got=%b want=%b", pass, obs, exp_out());
      end
    end
  endtask

  task automatic test_timeout();
    int pulses;
    pulses = 0;
    do_reset();
    packet_valid = 1'b1; datain = 2'd0; fifo_empty_0 = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step();
      packet_valid = 1'b0;
      if (wait_timeout === 1'b1) pulses++;
      total++;
      if (obs !== exp_out()) begin
        bad++; $display("FAIL timeout cyc=%0d got=%b want=%b", i, obs, exp_out());
      end
    end
    total++;
    if (pulses != 1) begin
      bad++; $display("FAIL timeout_pulses got=%0d want=1", pulses);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    packet_valid = 1'b1; datain = 2'd1;
    step(); step();
    fifo_full = 1'b1;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++;
    if (obs !== RESET_OUT) begin
      bad++; $display("FAIL reset_mid got=%b want=%b", obs, RESET_OUT);
    end
  endtask

  task automatic test_random();
    logic [2:0] fe;
    fe = 3'b111;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) fe = 3'($urandom_range(0, 7));
      {fifo_empty_2, fifo_empty_1, fifo_empty_0} = fe;
      reset            = ($urandom_range(0, 199) == 0);
      packet_valid     = ($urandom_range(0, 3) != 0);
      datain           = 2'($urandom_range(0, 3));
      fifo_full        = ($urandom_range(0, 3) == 0);
      soft_reset_0     = ($urandom_range(0, 47) == 0);
      soft_reset_1     = ($urandom_range(0, 47) == 0);
      soft_reset_2     = ($urandom_range(0, 47) == 0);
      parity_done      = ($urandom_range(0, 2) == 0);
      low_packet_valid = ($urandom_range(0, 1) == 0);
      step();
      total++;
      if (obs !== exp_out()) begin
        bad++; $display("FAIL random cyc=%0d got=%b want=%b", i, obs, exp_out());
      end
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_direct();
    test_busy_dest();
    test_invalid_addr();
    test_fifo_full();
    test_soft_reset();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
